store_buffer: RTL

- Sits directly downstream of the store-data sizing stage in the MEM stage.
- Accepts sized store data plus the 4-bit size thermometer, converts them to per-byte lane strobes using the low address bits, and queues the stores in a small FIFO.
- Drains the FIFO to data memory over a req/gnt handshake, so stores do not stall the pipeline while memory is busy.
- Also provides a fence/drain handshake and load-hazard detection against pending stores.

---
 rtl/store_buffer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Store buffer: sizes stores into byte lanes, queues them, drains over req/gnt,
// and flags loads that overlap pending stores. Define STORE_BUFFER_FWD_EN for load forwarding.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
`ifdef RV64
    parameter int DATA_W = 64
`else
    parameter int DATA_W = 32
`endif
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                st_valid_i,
    output logic                st_ready_o,
    input  logic [ADDR_W-1:0]   st_addr_i,
    input  logic [DATA_W-1:0]   st_data_i,
    input  logic [3:0]          st_size_en_i,
    output logic                st_err_o,
    input  logic                fence_req_i,
    output logic                fence_done_o,
    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic [ADDR_W-1:0]   ld_addr_i,
    input  logic [3:0]          ld_size_en_i,
    output logic                ld_stall_o,
    output logic                ld_fwd_hit_o,
    output logic [DATA_W-1:0]   ld_fwd_data_o
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {IDLE, ISSUE} state_t;

    function automatic int size_bytes(input logic [3:0] code);
        case (code)
            4'b0001: return 1;
            4'b0011: return 2;
            4'b0111: return 4;
            4'b1111: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [NB-1:0] lane_mask(input int bytes, input int off);
        logic [NB-1:0] m;
        for (int b = 0; b < NB; b++) begin
            m[b] = (b >= off) && (b < off + bytes);
        end
        return m;
    endfunction

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [NB-1:0]     strb_mem [DEPTH];

    state_t            state_reg;
    logic [PTR_W-1:0]  head_reg, tail_reg, head_next;
    logic [PTR_W:0]    count_reg, count_next;
    logic              err_reg;
    logic [ADDR_W-1:0] mem_addr_reg, nxt_addr;
    logic [DATA_W-1:0] mem_wdata_reg, nxt_data;
    logic [NB-1:0]     mem_wstrb_reg, nxt_strb;

    logic [OFF_W-1:0]  st_off;
    int                st_bytes;
    logic              st_bad, st_accept, st_push, mem_pop, bypass;
    logic [ADDR_W-1:0] st_word;
    logic [DATA_W-1:0] st_lane_data;
    logic [NB-1:0]     st_strb;

    assign st_off       = st_addr_i[OFF_W-1:0];
    assign st_word      = {st_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign st_lane_data = st_data_i << {st_off, 3'b000};

    always_comb begin
        st_bytes = size_bytes(st_size_en_i);
        st_bad   = (st_bytes == 0) || (int'(st_off) + st_bytes > NB);
        st_strb  = lane_mask(st_bytes, int'(st_off));
    end

    assign st_ready_o   = (count_reg < (PTR_W+1)'(DEPTH)) && !fence_req_i;
    assign st_accept    = st_valid_i && st_ready_o;
    assign st_push      = st_accept && !st_bad;
    assign mem_pop      = (state_reg == ISSUE) && mem_gnt_i;
    assign fence_done_o = fence_req_i && (count_reg == '0);

    // When the queue empties through this pop, the incoming store is the next head.
    always_comb begin
        count_next = count_reg;
        if (st_push && !mem_pop)
            count_next = count_reg + (PTR_W+1)'(1);
        else if (!st_push && mem_pop)
            count_next = count_reg - (PTR_W+1)'(1);
        head_next = head_reg + PTR_W'(mem_pop);
        bypass    = (count_reg == (PTR_W+1)'(mem_pop));
        nxt_addr  = bypass ? st_word      : addr_mem[head_next];
        nxt_data  = bypass ? st_lane_data : data_mem[head_next];
        nxt_strb  = bypass ? st_strb      : strb_mem[head_next];
    end

    always_ff @(posedge clk_i) begin
        if (st_push) begin
            addr_mem[tail_reg] <= st_word;
            data_mem[tail_reg] <= st_lane_data;
            strb_mem[tail_reg] <= st_strb;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            err_reg       <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
        end else begin
            err_reg   <= st_accept && st_bad;
            count_reg <= count_next;
            head_reg  <= head_next;
            if (st_push)
                tail_reg <= tail_reg + PTR_W'(1);
            // Request fields stay frozen while a request waits for its grant.
            if (state_reg == IDLE || mem_pop) begin
                if (count_next != '0) begin
                    state_reg     <= ISSUE;
                    mem_addr_reg  <= nxt_addr;
                    mem_wdata_reg <= nxt_data;
                    mem_wstrb_reg <= nxt_strb;
                end else begin
                    state_reg     <= IDLE;
                    mem_addr_reg  <= '0;
                    mem_wdata_reg <= '0;
                    mem_wstrb_reg <= '0;
                end
            end
        end
    end

    assign st_err_o    = err_reg;
    assign mem_req_o   = (state_reg == ISSUE);
    assign mem_addr_o  = mem_addr_reg;
    assign mem_wdata_o = mem_wdata_reg;
    assign mem_wstrb_o = mem_wstrb_reg;

    logic [ADDR_W-1:0] ld_word;
    logic [NB-1:0]     ld_mask;
    logic [DEPTH-1:0]  ovl_age;

    assign ld_word = {ld_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    always_comb ld_mask = lane_mask(size_bytes(ld_size_en_i), int'(ld_addr_i[OFF_W-1:0]));

    // Index gi is age order: 0 is the oldest pending store.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PTR_W-1:0] slot;
            assign slot        = head_reg + PTR_W'(gi);
            assign ovl_age[gi] = (count_reg > (PTR_W+1)'(gi)) && (addr_mem[slot] == ld_word)
                                 && |(strb_mem[slot] & ld_mask);
        end
    endgenerate

`ifdef STORE_BUFFER_FWD_EN
    logic [DEPTH-1:0]  cov_age;
    logic [DATA_W-1:0] data_age [DEPTH];
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_fwd
            assign cov_age[gi]  = ((strb_mem[g_age[gi].slot] & ld_mask) == ld_mask);
            assign data_age[gi] = data_mem[g_age[gi].slot];
        end
    endgenerate

    // The youngest overlapping store decides: full cover forwards, partial stalls.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ovl_age[k]) begin
                fwd_hit  = cov_age[k];
                fwd_data = data_age[k];
            end
        end
    end

    assign ld_stall_o    = |ovl_age && !fwd_hit;
    assign ld_fwd_hit_o  = fwd_hit;
    assign ld_fwd_data_o = fwd_hit ? fwd_data : '0;
`else
    assign ld_stall_o    = |ovl_age;
    assign ld_fwd_hit_o  = 1'b0;
    assign ld_fwd_data_o = '0;
`endif

endmodule
